// File: rtl/pool_pkg.sv
// Shared constants, counter widths and the signed compare helper for the
// 2x2 stride-2 max-pooling stage.
package pool_pkg;

   localparam int DEF_D_WIDTH = 32;
   localparam int DEF_IMG_W   = 24;
   localparam int DEF_IMG_H   = 24;
   localparam int DEF_CH_NUM  = 30;
   localparam int DEF_SAT_MAX = 32767;

   localparam int COL_W = $clog2(DEF_IMG_W);
   localparam int ROW_W = $clog2(DEF_IMG_H);
   localparam int CH_W  = $clog2(DEF_CH_NUM);

   // Two's-complement max; ties return a, which is harmless since both are equal.
   function automatic logic [DEF_D_WIDTH-1:0] max2(input logic [DEF_D_WIDTH-1:0] a,
                                                   input logic [DEF_D_WIDTH-1:0] b);
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer holding the horizontal maxima of the even input row until
// the matching odd row arrives. Combinational read, registered write.
module pool_line_buf
   import pool_pkg::*;
#(
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int DEPTH   = DEF_IMG_W / 2,
   parameter int AW      = COL_W - 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [AW-1:0]      addr,
   input  logic [D_WIDTH-1:0] wr_data,
   output logic [D_WIDTH-1:0] rd_data
);

   logic [D_WIDTH-1:0] mem_q [DEPTH];
   logic [D_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[addr] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[addr];

endmodule

// File: rtl/pool_max2x2.sv
// 2x2 stride-2 max pooling over a raster stream of channels.
// Optional clamp of the pooled value to SAT_MAX when POOL_SAT_EN is defined.
module pool_max2x2
   import pool_pkg::*;
#(
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int CH_NUM  = DEF_CH_NUM,
   parameter int SAT_MAX = DEF_SAT_MAX
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pool_clr,
   input  logic [D_WIDTH-1:0] in_data,
   input  logic               in_vld,
   output logic [D_WIDTH-1:0] pool_data,
   output logic               pool_vld,
   output logic [3:0]         pool_col,
   output logic [3:0]         pool_row,
   output logic [4:0]         pool_ch,
   output logic               ch_done,
   output logic               frame_done
);

   // in_vld: a sample is taken on every edge where in_vld is high and pool_clr
   // is low; there is no backpressure. pool_vld: one-cycle pulse per pooled
   // pixel, with data, indices and done flags valid in the same cycle.

   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [D_WIDTH-1:0] h_q, h_d;
   logic [D_WIDTH-1:0] pool_data_q, pool_data_d;
   logic               pool_vld_q, pool_vld_d;
   logic [3:0]         pool_col_q, pool_col_d;
   logic [3:0]         pool_row_q, pool_row_d;
   logic [4:0]         pool_ch_q, pool_ch_d;
   logic               ch_done_q, ch_done_d;
   logic               frame_done_q, frame_done_d;

   logic               accept;
   logic               last_col, last_row, last_ch;
   logic [D_WIDTH-1:0] hmax;
   logic [D_WIDTH-1:0] lb_rd;
   logic [D_WIDTH-1:0] pooled;
   logic [D_WIDTH-1:0] pooled_out;
   logic               lb_wr_en;

   assign accept   = in_vld & ~pool_clr;
   assign last_col = (col_q == COL_W'(IMG_W - 1));
   assign last_row = (row_q == ROW_W'(IMG_H - 1));
   assign last_ch  = (ch_q == CH_W'(CH_NUM - 1));
   assign hmax     = max2(h_q, in_data);
   assign lb_wr_en = accept & col_q[0] & ~row_q[0];

   pool_line_buf #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (IMG_W / 2),
      .AW      (COL_W - 1)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (lb_wr_en),
      .addr    (col_q[COL_W-1:1]),
      .wr_data (hmax),
      .rd_data (lb_rd)
   );

   assign pooled = max2(lb_rd, hmax);

`ifdef POOL_SAT_EN
   // Only the ceiling is clamped; negative maxima pass through untouched.
   assign pooled_out = ($signed(pooled) > $signed(D_WIDTH'(SAT_MAX))) ?
                       D_WIDTH'(SAT_MAX) : pooled;
`else
   logic [D_WIDTH-1:0] unused_sat_max;
   assign unused_sat_max = D_WIDTH'(SAT_MAX);
   assign pooled_out     = pooled;
`endif

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      ch_d         = ch_q;
      h_d          = h_q;
      pool_data_d  = pool_data_q;
      pool_vld_d   = 1'b0;
      pool_col_d   = pool_col_q;
      pool_row_d   = pool_row_q;
      pool_ch_d    = pool_ch_q;
      ch_done_d    = 1'b0;
      frame_done_d = 1'b0;

      if (pool_clr) begin
         col_d = '0;
         row_d = '0;
         ch_d  = '0;
      end else if (in_vld) begin
         if (!col_q[0]) begin
            h_d = in_data;
         end else if (row_q[0]) begin
            pool_data_d  = pooled_out;
            pool_vld_d   = 1'b1;
            pool_col_d   = 4'(col_q >> 1);
            pool_row_d   = 4'(row_q >> 1);
            pool_ch_d    = 5'(ch_q);
            ch_done_d    = last_col & last_row;
            frame_done_d = last_col & last_row & last_ch;
         end

         // Raster position: column, then row, then channel; channel wraps so
         // consecutive frames need no clear in between.
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d = '0;
               ch_d  = last_ch ? '0 : ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         ch_q         <= '0;
         h_q          <= '0;
         pool_data_q  <= '0;
         pool_vld_q   <= 1'b0;
         pool_col_q   <= '0;
         pool_row_q   <= '0;
         pool_ch_q    <= '0;
         ch_done_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         ch_q         <= ch_d;
         h_q          <= h_d;
         pool_data_q  <= pool_data_d;
         pool_vld_q   <= pool_vld_d;
         pool_col_q   <= pool_col_d;
         pool_row_q   <= pool_row_d;
         pool_ch_q    <= pool_ch_d;
         ch_done_q    <= ch_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pool_data  = pool_data_q;
   assign pool_vld   = pool_vld_q;
   assign pool_col   = pool_col_q;
   assign pool_row   = pool_row_q;
   assign pool_ch    = pool_ch_q;
   assign ch_done    = ch_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/pool_max2x2.md
Name: pool_max2x2

Overview:
- 2x2 stride-2 max-pooling stage placed directly downstream of the 5x5 convolution stage.
- Consumes the conv stage's ReLU'd result stream: 24x24 pixels per channel, 30 channels, raster order, one valid pixel per in_vld.
- Emits 12x12 pooled pixels per channel, each tagged with channel/row/col indices, to the next layer's buffer.

Parameters:
- D_WIDTH, 32, data width of input and output pixels (two's complement).
- IMG_W, 24, input columns per row (must be even).
- IMG_H, 24, input rows per channel (must be even).
- CH_NUM, 30, channels per frame.
- SAT_MAX, 32767, clamp ceiling, used only when POOL_SAT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pool_clr  in  1  synchronous clear of counters and valid outputs; pulse once before each frame
- in_data  in  D_WIDTH  conv result pixel (signed)
- in_vld  in  1  in_data valid; arbitrary gaps allowed, no backpressure
- pool_data  out  D_WIDTH  pooled pixel (signed)
- pool_vld  out  1  pool_data and index outputs valid, one-cycle pulse per pixel
- pool_col  out  4  output column, 0..IMG_W/2-1
- pool_row  out  4  output row, 0..IMG_H/2-1
- pool_ch  out  5  output channel, 0..CH_NUM-1
- ch_done  out  1  one-cycle pulse coincident with the last pooled pixel of a channel
- frame_done  out  1  one-cycle pulse coincident with the last pooled pixel of channel CH_NUM-1

Behaviour:
- Reset: all outputs 0; col_cnt, row_cnt, ch_cnt, h_reg and line buffer cleared.
- Counters:
  - col_cnt advances only on in_vld and wraps at IMG_W-1.
  - On col_cnt wrap, row_cnt increments; it wraps at IMG_H-1.
  - On row_cnt wrap, ch_cnt increments; it wraps at CH_NUM-1 back to 0, so the next frame needs no pool_clr.
- Even column (col_cnt[0]=0) with in_vld: h_reg <= in_data.
- Odd column with in_vld: hmax = signed max(h_reg, in_data), computed combinationally.
  - Even row (row_cnt[0]=0): line_buf[col_cnt>>1] <= hmax. No output.
  - Odd row: pool_data <= signed max(line_buf[col_cnt>>1], hmax) and pool_vld <= 1 on the next edge.
  - Indices registered alongside: pool_col = col_cnt>>1, pool_row = row_cnt>>1, pool_ch = ch_cnt.
- Latency: pool_vld rises 1 cycle after the accepting edge of the bottom-right pixel of each 2x2 window.
- Throughput: one output per 4 inputs; back-to-back in_vld every cycle is supported.
- Equal operands: either value may be chosen (the result is identical).
- ch_done is asserted with the output where col_cnt=IMG_W-1 and row_cnt=IMG_H-1.
- frame_done is additionally qualified by ch_cnt=CH_NUM-1.
- pool_clr and in_vld in the same cycle: clear wins, the sample is dropped, counters go to 0, pool_vld/ch_done/frame_done go to 0.
- Line buffer contents are not cleared by pool_clr; every entry is rewritten on the next even row before it is read.
- rst_n asserted mid-frame: immediate return to reset state; no partial output is produced afterwards.

Optional Feature:
- Macro: POOL_SAT_EN.
- Defined: pool_data = min(pooled max, SAT_MAX) using a signed compare. Pooled values below 0 pass through unchanged.
- Undefined: pool_data is the raw pooled max; SAT_MAX is unused.
- Latency and valid timing are identical in both builds.

Decomposition:
- Package pool_pkg:
  - Default constants IMG_W=24, IMG_H=24, CH_NUM=30, D_WIDTH=32.
  - Derived widths for the col/row/ch counters.
  - A signed max2 function shared by the horizontal and vertical compares.
- Sub-module pool_line_buf:
  - IMG_W/2 x D_WIDTH register array.
  - One write port and one combinational read port, both addressed by col_cnt>>1.
  - Write enable = in_vld & col odd & row even.
- Counters and the output register stay in the top module.

Test Plan:
- Single 2x2 window:
  - Stimulus: row0 cols0-1 = 5, 9; row1 cols0-1 = 3, 7.
  - Expected: pool_data=9, pool_col=0, pool_row=0, pool_ch=0, pool_vld high exactly 1 cycle after the 4th sample.
- Signed compare:
  - Stimulus: window {-4, -2, -8, -1}.
  - Expected: pool_data=-1.
- Full channel of ramp data in(r,c)=r*24+c with continuous in_vld:
  - 144 pool_vld pulses.
  - Pixel (i,j) = (2i+1)*24 + 2j+1.
  - ch_done pulses once, with the pixel of value 575.
- Gapped stream, matching the conv stage timing (24 valid cycles, 8 idle, per row) for 30 channels:
  - 4320 outputs total; pool_ch steps 0..29.
  - frame_done pulses once, on the last output.
  - Counters back at 0 afterwards.
- Mid-frame disturbance:
  - pool_clr asserted at row 5 col 13 together with in_vld: no output for that sample; the next sample is treated as row 0 col 0.
  - rst_n pulsed mid-row: all outputs read 0 during reset.
- POOL_SAT_EN build:
  - Window max 40000 -> pool_data=32767.
  - Window max 100 -> pool_data=100.
